// File: rtl/rv32imf_apu_dispatcher.sv
// Core-side APU request/response initiator: holds one request until granted, tracks
// in-flight ops in an in-order tag FIFO, registers writeback and keeps sticky fflags.
module rv32imf_apu_dispatcher #(
  parameter int unsigned DEPTH            = 4,
  parameter int unsigned APU_WOP_CPU      = 6,
  parameter int unsigned APU_NDSFLAGS_CPU = 15,
  parameter int unsigned APU_NUSFLAGS_CPU = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        issue_valid_i,
  output logic                        issue_ready_o,
  input  logic [2:0][31:0]            issue_operands_i,
  input  logic [APU_WOP_CPU-1:0]      issue_op_i,
  input  logic [APU_NDSFLAGS_CPU-1:0] issue_flags_i,
  input  logic [4:0]                  issue_rd_i,
  input  logic                        issue_long_i,
  output logic                        apu_req_o,
  input  logic                        apu_gnt_i,
  output logic [2:0][31:0]            apu_operands_o,
  output logic [APU_WOP_CPU-1:0]      apu_op_o,
  output logic [APU_NDSFLAGS_CPU-1:0] apu_flags_o,
  input  logic                        apu_rvalid_i,
  input  logic [31:0]                 apu_rdata_i,
  input  logic [APU_NUSFLAGS_CPU-1:0] apu_rflags_i,
  output logic                        wb_valid_o,
  output logic [4:0]                  wb_rd_o,
  output logic [31:0]                 wb_data_o,
  output logic [APU_NUSFLAGS_CPU-1:0] fflags_o,
  input  logic                        fflags_clr_i,
  output logic [31:0]                 rd_pending_o,
  output logic                        busy_o,
  output logic                        err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [4:0] rd;
    logic       is_long;
  } fifo_ent_t;

  // Request hold register
  logic                        req_vld_q;
  logic [2:0][31:0]            req_operands_q;
  logic [APU_WOP_CPU-1:0]      req_op_q;
  logic [APU_NDSFLAGS_CPU-1:0] req_flags_q;
  logic [4:0]                  req_rd_q;
  logic                        req_long_q;

  // In-order tag FIFO
  fifo_ent_t                   fifo_q [DEPTH];
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [AW:0]                 occ_q;
  fifo_ent_t                   head;

  logic                        long_pend_q;
  logic [31:0]                 rd_pending_q, rd_pending_d;
  logic                        wb_valid_q;
  logic [4:0]                  wb_rd_q;
  logic [31:0]                 wb_data_q;
  logic [APU_NUSFLAGS_CPU-1:0] fflags_q;
  logic                        err_q;

  logic [AW:0]                 cnt;
  logic                        accept, grant, pop, fifo_empty;

  assign cnt        = occ_q + {{AW{1'b0}}, req_vld_q};
  assign fifo_empty = (occ_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  // Slot check uses current occupancy only: a same-cycle pop does not free a slot.
  assign issue_ready_o = (~req_vld_q | apu_gnt_i) & ~long_pend_q & ~rd_pending_q[issue_rd_i]
                       & (cnt < DEPTH_C) & (~issue_long_i | (cnt == '0));

  assign accept = issue_valid_i & issue_ready_o;
  assign grant  = req_vld_q & apu_gnt_i;
  assign pop    = apu_rvalid_i & ~fifo_empty;

  always_comb begin
    rd_pending_d = rd_pending_q;
    if (pop)    rd_pending_d[head.rd]    = 1'b0;
    if (accept) rd_pending_d[issue_rd_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_vld_q      <= 1'b0;
      req_operands_q <= '0;
      req_op_q       <= '0;
      req_flags_q    <= '0;
      req_rd_q       <= '0;
      req_long_q     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      occ_q          <= '0;
      long_pend_q    <= 1'b0;
      rd_pending_q   <= '0;
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
      fflags_q       <= '0;
      err_q          <= 1'b0;
    end else begin
      // A new accept in the grant cycle keeps the request line up for back-to-back issue.
      if (accept) begin
        req_vld_q      <= 1'b1;
        req_operands_q <= issue_operands_i;
        req_op_q       <= issue_op_i;
        req_flags_q    <= issue_flags_i;
        req_rd_q       <= issue_rd_i;
        req_long_q     <= issue_long_i;
      end else if (grant) begin
        req_vld_q      <= 1'b0;
      end

      if (grant) begin
        fifo_q[wr_ptr_q] <= '{rd: req_rd_q, is_long: req_long_q};
        wr_ptr_q         <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);

      case ({grant, pop})
        2'b10:   occ_q <= occ_q + (AW+1)'(1);
        2'b01:   occ_q <= occ_q - (AW+1)'(1);
        default: occ_q <= occ_q;
      endcase

      wb_valid_q <= pop;
      if (pop) begin
        wb_rd_q   <= head.rd;
        wb_data_q <= apu_rdata_i;
      end
      err_q <= apu_rvalid_i & fifo_empty;

      rd_pending_q <= rd_pending_d;

      if (pop && head.is_long) long_pend_q <= 1'b0;
      else if (accept && issue_long_i) long_pend_q <= 1'b1;

      if (fflags_clr_i) fflags_q <= pop ? apu_rflags_i : '0;
      else if (pop)     fflags_q <= fflags_q | apu_rflags_i;
    end
  end

  assign apu_req_o      = req_vld_q;
  assign apu_operands_o = req_operands_q;
  assign apu_op_o       = req_op_q;
  assign apu_flags_o    = req_flags_q;
  assign wb_valid_o     = wb_valid_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_data_o      = wb_data_q;
  assign fflags_o       = fflags_q;
  assign rd_pending_o   = rd_pending_q;
  assign busy_o         = (cnt != '0) | wb_valid_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_rv32imf_apu_dispatcher.sv
// Bench for rv32imf_apu_dispatcher: queue-based reference model plus an in-order APU
// responder with configurable latency; directed scenarios followed by random traffic.
module tb_rv32imf_apu_dispatcher;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_i, issue_valid_i, issue_ready_o, issue_long_i;
  logic [2:0][31:0] issue_operands_i, apu_operands_o;
  logic [5:0]      issue_op_i, apu_op_o;
  logic [14:0]     issue_flags_i, apu_flags_o;
  logic [4:0]      issue_rd_i, wb_rd_o;
  logic            apu_req_o, apu_gnt_i, apu_rvalid_i, wb_valid_o, fflags_clr_i, busy_o, err_o;
  logic [31:0]     apu_rdata_i, wb_data_o, rd_pending_o;
  logic [4:0]      apu_rflags_i, fflags_o;

  rv32imf_apu_dispatcher #(.DEPTH(DEPTH), .APU_WOP_CPU(6), .APU_NDSFLAGS_CPU(15),
                           .APU_NUSFLAGS_CPU(5)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_operands_i(issue_operands_i), .issue_op_i(issue_op_i),
    .issue_flags_i(issue_flags_i), .issue_rd_i(issue_rd_i), .issue_long_i(issue_long_i),
    .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i), .apu_operands_o(apu_operands_o),
    .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o), .apu_rvalid_i(apu_rvalid_i),
    .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i), .rd_pending_o(rd_pending_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  int checks = 0, errors = 0;

  task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct packed { bit [4:0] rd; bit lng; } ent_t;
  ent_t      mq[$];
  bit        m_req, m_long, m_longp, m_wbv, m_err;
  bit [95:0] m_opnd;
  bit [5:0]  m_op;
  bit [14:0] m_flg;
  bit [4:0]  m_rd, m_wbrd, m_ff;
  bit [31:0] m_pend, m_wbd;

  // APU responder: due cycles of granted ops, strictly increasing (in order)
  int due[$];
  int cyc = 0;
  int lat_lo = 1, lat_hi = 4;

  // Stimulus controls
  bit       g_rst = 1, g_valid = 0, g_long = 0, g_gnt = 1, g_clr = 0, g_hold = 0;
  bit       g_spur = 0, g_rf_en = 0, g_clr_on_rv = 0;
  bit [4:0] g_rd = 0, g_rf = 0;
  bit [95:0] g_last_opnd;

  // Sampled DUT outputs of the latest step
  bit       obs_ready, obs_req, obs_wbv, obs_err;
  bit [4:0] obs_wbrd, obs_ff;
  bit [31:0] obs_pend;
  bit [95:0] obs_opnd;

  task automatic step();
    bit rv, from_due, ready_e, acc, gnt_e, pop, clr;
    int cnt, d;
    ent_t h;
    bit [31:0] rdata;
    bit [4:0]  rf;
    bit [95:0] opnd;
    bit [5:0]  op;
    bit [14:0] flg;
    @(negedge clk);
    from_due = !g_hold && due.size() > 0 && due[0] <= cyc;
    rv    = g_spur || from_due;
    rdata = $urandom;
    rf    = g_rf_en ? g_rf : 5'($urandom);
    opnd  = {$urandom, $urandom, $urandom};
    op    = 6'($urandom);
    flg   = 15'($urandom);
    clr   = g_clr || (g_clr_on_rv && rv);
    rst_i = g_rst; issue_valid_i = g_valid; issue_rd_i = g_rd; issue_long_i = g_long;
    issue_operands_i = opnd; issue_op_i = op; issue_flags_i = flg;
    apu_gnt_i = g_gnt; apu_rvalid_i = rv; apu_rdata_i = rdata; apu_rflags_i = rf;
    fflags_clr_i = clr;
    g_last_opnd = opnd;

    cnt = mq.size() + int'(m_req);
    ready_e = (!m_req || g_gnt) && !m_longp && !m_pend[g_rd] && cnt < DEPTH && (!g_long || cnt == 0);
    #1;
    check_eq("issue_ready", 96'(issue_ready_o), 96'(ready_e));
    check_eq("apu_req", 96'(apu_req_o), 96'(m_req));
    check_eq("apu_operands", 96'(apu_operands_o), m_opnd);
    check_eq("apu_op", 96'(apu_op_o), 96'(m_op));
    check_eq("apu_flags", 96'(apu_flags_o), 96'(m_flg));
    check_eq("wb_valid", 96'(wb_valid_o), 96'(m_wbv));
    check_eq("wb_rd", 96'(wb_rd_o), 96'(m_wbrd));
    check_eq("wb_data", 96'(wb_data_o), 96'(m_wbd));
    check_eq("fflags", 96'(fflags_o), 96'(m_ff));
    check_eq("rd_pending", 96'(rd_pending_o), 96'(m_pend));
    check_eq("busy", 96'(busy_o), 96'((cnt != 0) || m_wbv));
    check_eq("err", 96'(err_o), 96'(m_err));
    obs_ready = issue_ready_o; obs_req = apu_req_o; obs_wbv = wb_valid_o; obs_err = err_o;
    obs_wbrd = wb_rd_o; obs_ff = fflags_o; obs_pend = rd_pending_o; obs_opnd = apu_operands_o;

    gnt_e = m_req && g_gnt;
    acc   = g_valid && ready_e;
    if (from_due) void'(due.pop_front());
    // The APU side sees a grant even in a reset cycle and will answer it later.
    if (gnt_e) begin
      d = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (due.size() > 0 && d <= due[$]) d = due[$] + 1;
      due.push_back(d);
    end
    if (g_rst) begin
      mq.delete();
      m_req = 0; m_long = 0; m_longp = 0; m_wbv = 0; m_err = 0;
      m_opnd = '0; m_op = '0; m_flg = '0; m_rd = '0; m_wbrd = '0; m_ff = '0;
      m_pend = '0; m_wbd = '0;
    end else begin
      pop   = rv && mq.size() > 0;
      m_err = rv && mq.size() == 0;
      m_wbv = pop;
      if (pop) begin
        h = mq.pop_front();
        m_wbrd = h.rd; m_wbd = rdata; m_pend[h.rd] = 1'b0;
        if (h.lng) m_longp = 1'b0;
      end
      if (clr) m_ff = pop ? rf : 5'd0;
      else if (pop) m_ff = m_ff | rf;
      if (gnt_e) mq.push_back('{rd: m_rd, lng: m_long});
      if (acc) begin
        m_req = 1; m_opnd = opnd; m_op = op; m_flg = flg; m_rd = g_rd; m_long = g_long;
        m_pend[g_rd] = 1'b1;
        if (g_long) m_longp = 1'b1;
      end else if (gnt_e) m_req = 0;
    end
    cyc++;
  endtask

  task automatic idle_inputs();
    g_rst = 0; g_valid = 0; g_long = 0; g_gnt = 1; g_clr = 0; g_hold = 0;
    g_spur = 0; g_rf_en = 0; g_clr_on_rv = 0;
  endtask

  task automatic drain();
    int n = 0;
    idle_inputs();
    while ((mq.size() != 0 || m_req || due.size() != 0) && n < 60) begin step(); n++; end
    step();
    check_eq("drain_timeout", 96'(n < 60), 96'(1));
  endtask

  task automatic wait_wb(input string tag);
    int n = 0;
    g_valid = 0;
    do begin step(); n++; end while (!obs_wbv && n < 20);
    check_eq(tag, 96'(obs_wbv), 96'(1));
  endtask

  task automatic random_step();
    g_rst   = ($urandom_range(299, 0) == 0);
    g_valid = ($urandom_range(9, 0) < 6);
    g_long  = ($urandom_range(9, 0) == 0);
    g_rd    = 5'($urandom_range(7, 0));
    g_gnt   = ($urandom_range(9, 0) < 7);
    g_clr   = ($urandom_range(19, 0) == 0);
    g_spur  = ($urandom_range(49, 0) == 0);
    step();
  endtask

  initial begin
    int reqs, wbn, waited;
    bit seen7;
    bit [4:0] wbl[4];
    bit [95:0] held;

    rst_i = 1; issue_valid_i = 0; issue_long_i = 0; issue_rd_i = '0; issue_operands_i = '0;
    issue_op_i = '0; issue_flags_i = '0; apu_gnt_i = 0; apu_rvalid_i = 0; apu_rdata_i = '0;
    apu_rflags_i = '0; fflags_clr_i = 0;

    // Reset, then traffic, then a 2-cycle reset mid-traffic and a late response
    step(); step();
    idle_inputs();
    for (int i = 0; i < 20; i++) random_step();
    g_rst = 0; g_valid = 1; g_rd = 3; g_gnt = 0; step();
    g_rst = 1; step(); step();
    idle_inputs(); step();
    check_eq("rst_req", 96'(obs_req), 96'(0));
    check_eq("rst_pend", 96'(obs_pend), 96'(0));
    check_eq("rst_ff", 96'(obs_ff), 96'(0));
    g_spur = 1; step(); g_spur = 0; step();
    check_eq("late_err", 96'(obs_err), 96'(1));
    check_eq("late_no_wb", 96'(obs_wbv), 96'(0));
    drain();

    // Back-to-back with 3-cycle latency
    lat_lo = 3; lat_hi = 3; reqs = 0; wbn = 0;
    for (int k = 1; k <= 4; k++) begin
      g_valid = 1; g_rd = 5'(k); step();
      check_eq("b2b_accept", 96'(obs_ready), 96'(1));
      if (obs_req) reqs++;
    end
    g_valid = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (obs_req) reqs++;
      if (obs_wbv && wbn < 4) begin wbl[wbn] = obs_wbrd; wbn++; end
    end
    check_eq("b2b_req_cycles", 96'(reqs), 96'(4));
    check_eq("b2b_wb_count", 96'(wbn), 96'(4));
    for (int k = 0; k < 4; k++) check_eq("b2b_wb_order", 96'(wbl[k]), 96'(k + 1));
    check_eq("b2b_pend_clear", 96'(obs_pend), 96'(0));
    drain();

    // Grant stall: payload held, issue blocked
    g_valid = 1; g_rd = 9; step(); held = g_last_opnd;
    g_gnt = 0; g_rd = 10;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("stall_ready", 96'(obs_ready), 96'(0));
      check_eq("stall_operands", obs_opnd, held);
    end
    g_gnt = 1; step();
    drain();

    // Capacity: four in flight, fifth blocked until the cycle after the first response
    g_hold = 1;
    for (int k = 11; k <= 14; k++) begin
      g_valid = 1; g_rd = 5'(k); step();
      check_eq("cap_accept", 96'(obs_ready), 96'(1));
    end
    g_rd = 15;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("cap_full", 96'(obs_ready), 96'(0));
    end
    g_hold = 0; step();
    check_eq("cap_pop_no_free", 96'(obs_ready), 96'(0));
    step();
    check_eq("cap_freed", 96'(obs_ready), 96'(1));
    drain();

    // Long op waits for an empty pipe and blocks later issue until it returns
    lat_lo = 3; lat_hi = 3;
    g_valid = 1; g_rd = 1; step(); g_rd = 2; step();
    g_rd = 7; g_long = 1; waited = 0;
    do begin step(); waited++; end while (!obs_ready && waited < 30);
    check_eq("long_accepted", 96'(obs_ready), 96'(1));
    check_eq("long_waited", 96'(waited > 1), 96'(1));
    g_long = 0; g_rd = 8; seen7 = 0; waited = 0;
    step();
    check_eq("long_blocks_add", 96'(obs_ready), 96'(0));
    do begin
      step(); waited++;
      if (obs_wbv && obs_wbrd == 5'd7) seen7 = 1;
    end while (!obs_ready && waited < 30);
    check_eq("add_accepted", 96'(obs_ready), 96'(1));
    check_eq("div_wb_first", 96'(seen7), 96'(1));
    drain();

    // Sticky flags, clear-with-response, RAW stall
    g_clr = 1; step(); g_clr = 0;
    g_rf_en = 1; g_rf = 5'b00001;
    g_valid = 1; g_rd = 5; step();
    step();
    check_eq("raw_stall", 96'(obs_ready), 96'(0));
    wait_wb("ff1_wb");
    g_rf = 5'b10000; g_valid = 1; g_rd = 6; step(); wait_wb("ff2_wb");
    check_eq("ff_sticky", 96'(obs_ff), 96'(5'b10001));
    g_rf = 5'b00100; g_clr_on_rv = 1; g_valid = 1; g_rd = 4; step(); wait_wb("ff3_wb");
    check_eq("ff_clr_rv", 96'(obs_ff), 96'(5'b00100));
    drain();

    // Random traffic
    lat_lo = 1; lat_hi = 5;
    for (int i = 0; i < 1500; i++) random_step();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/rv32imf_apu_dispatcher.md
Name: rv32imf_apu_dispatcher

Overview:
Core-side initiator of the APU request/response interface; the FP wrapper sits on the far end as responder. Accepts decoded FP instructions from the ID stage, drives apu_req/operands/op/flags until granted, and tracks up to DEPTH in-flight ops in an in-order tag FIFO. It registers the APU result into a writeback port, accumulates sticky fflags, and exports a pending-rd scoreboard so decode can stall on RAW hazards.

Parameters:
DEPTH, 4, max ops outstanding (held request + granted-awaiting-result); power of 2, >=2
APU_WOP_CPU, 6, width of apu op field
APU_NDSFLAGS_CPU, 15, width of downstream flags (int_fmt, src_fmt, dst_fmt, rnd_mode)
APU_NUSFLAGS_CPU, 5, width of upstream status flags (NV, DZ, OF, UF, NX)

Ports:
clk_i  in  1  clock; all state on rising edge
rst_i  in  1  synchronous reset, active-high
issue_valid_i  in  1  ID stage presents an FP op
issue_ready_o  out  1  dispatcher accepts op this cycle
issue_operands_i  in  3x32  operands a, b, c
issue_op_i  in  APU_WOP_CPU  {vec_op, op_mod, op}
issue_flags_i  in  APU_NDSFLAGS_CPU  format/rounding flags
issue_rd_i  in  5  destination FP register
issue_long_i  in  1  op is div/sqrt (variable latency, may reorder)
apu_req_o  out  1  request to APU
apu_gnt_i  in  1  APU accepted request
apu_operands_o  out  3x32  held operands
apu_op_o  out  APU_WOP_CPU  held op
apu_flags_o  out  APU_NDSFLAGS_CPU  held flags
apu_rvalid_i  in  1  APU result valid (no backpressure)
apu_rdata_i  in  32  APU result
apu_rflags_i  in  APU_NUSFLAGS_CPU  APU status flags
wb_valid_o  out  1  writeback strobe
wb_rd_o  out  5  writeback register
wb_data_o  out  32  writeback data
fflags_o  out  APU_NUSFLAGS_CPU  sticky accumulated flags
fflags_clr_i  in  1  clear fflags (CSR write)
rd_pending_o  out  32  bit i set while an op targeting f[i] is in flight
busy_o  out  1  any op held or in flight
err_o  out  1  one-cycle pulse: rvalid with empty FIFO

Behaviour:
- Reset (rst_i high at clk edge): all outputs/registers 0, FIFO empty, scoreboard clear, long_pend_q=0. Reset mid-op drops all state; responses arriving after reset for pre-reset ops raise err_o and are discarded.
- Request hold register (req_vld_q + payload). apu_req_o = req_vld_q. Payload stable while apu_req_o=1 and apu_gnt_i=0; never withdrawn once raised.
- cnt = FIFO occupancy + req_vld_q.
- issue_ready_o = (!req_vld_q | apu_gnt_i) & !long_pend_q & !rd_pending_o[issue_rd_i] & (cnt - (apu_rvalid_i ? 0 : 0) < DEPTH) & (!issue_long_i | cnt==0). A pop in the same cycle does not free a slot.
- Accept (issue_valid_i & issue_ready_o): load hold register next cycle; set rd_pending[issue_rd_i]; if issue_long_i set long_pend_q.
- Grant (apu_req_o & apu_gnt_i): push {rd, long} into FIFO; clear req_vld_q unless a new accept occurs in the same cycle (back-to-back: one op per cycle when gnt held high).
- Response (apu_rvalid_i): if FIFO non-empty, pop head; next cycle wb_valid_o=1, wb_rd_o=head.rd, wb_data_o=apu_rdata_i (latency 1, registered). Clear rd_pending[head.rd] on the same edge wb_valid_o rises. If head.long, clear long_pend_q on that edge. If FIFO empty: err_o=1 next cycle, no writeback, no state change.
- Push and pop in the same cycle are legal; occupancy unchanged. FIFO full never pushed (guarded by cnt<DEPTH).
- Long ops issue only with nothing in flight and block all issue until their result returns, so responses are always in issue order.
- fflags: on rvalid with non-empty FIFO, fflags_q |= apu_rflags_i. fflags_clr_i clears; clr and rvalid in the same cycle gives fflags_q = apu_rflags_i.
- busy_o = (cnt != 0) | wb_valid_o.
- WAW is prevented by the rd_pending stall; set and clear never target the same bit in one cycle.

Test Plan:
- Reset: hold rst_i 2 cycles mid-traffic -> all outputs 0; a late apu_rvalid_i -> err_o pulse, wb_valid_o stays 0.
- Back-to-back: 4 ops to rd 1..4 with gnt=1 and 3-cycle APU latency -> apu_req_o high 4 consecutive cycles; wb_rd_o=1,2,3,4 in order, each 1 cycle after rvalid; rd_pending_o returns to 0.
- Grant stall: gnt=0 for 5 cycles -> apu_operands_o/op/flags constant; issue_ready_o=0; after gnt, exactly one FIFO push.
- Capacity: DEPTH=4, gnt=1, no rvalid -> 5th op sees issue_ready_o=0 until first rvalid+1.
- Long op: issue div to rd 7 with 2 ops in flight -> stalled until cnt==0; while div pending, an add to rd 8 is stalled; div result -> wb_rd_o=7, then add accepted.
- Flags/hazard: op to rd 5 returns rflags=5'b00001, next rflags=5'b10000 -> fflags_o=5'b10001; fflags_clr_i with rvalid rflags=5'b00100 -> 5'b00100; issue to rd 5 while pending -> issue_ready_o=0.
